// File: rtl/bw_io_jp_bsr_tap_ctl.sv
// JTAG TAP controller for a boundary-scan chain.
// It holds the TAP state machine, a 4-bit instruction register, the 32-bit IDCODE register
// and the 1-bit bypass register. It also drives the control strobes for the external BSR cells.
//
// state    | meaning
// ---------+------------------------------------------------
// TLR      | test-logic-reset, IR forced to IDCODE
// RTI      | run-test/idle
// SEL_DR   | select DR-scan column
// CAP_DR   | parallel capture into selected DR
// SH_DR    | serial shift of selected DR
// EX1_DR   | exit-1 DR
// PAUSE_DR | DR shift paused
// EX2_DR   | exit-2 DR
// UPD_DR   | DR update (BSR update_dr pulse)
// SEL_IR   | select IR-scan column
// CAP_IR   | load 4'b0001 into IR shift
// SH_IR    | serial shift of IR
// EX1_IR   | exit-1 IR
// PAUSE_IR | IR shift paused
// EX2_IR   | exit-2 IR
// UPD_IR   | IR shift copied to IR latch on exit
module bw_io_jp_bsr_tap_ctl #(
    parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
    input  logic tck,
    input  logic trst_l,
    input  logic tms,
    input  logic tdi,
    input  logic bsr_tail,
    output logic tdo,
    output logic tdo_en,
    output logic bsr_si,
    output logic shift_dr,
    output logic clock_dr,
    output logic update_dr,
    output logic mode_ctl,
    output logic bypass_enable,
    output logic ps_select
);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tap_state_t;

    localparam logic [3:0] INS_EXTEST    = 4'h0;
    localparam logic [3:0] INS_SAMPLE    = 4'h1;
    localparam logic [3:0] INS_IDCODE    = 4'h2;
    localparam logic [3:0] INS_PS_EXTEST = 4'h4;

    tap_state_t  state, next_state;
    logic [3:0]  ir_shift, ir_latch;
    logic [31:0] idcode_reg;
    logic        bypass_reg;
    logic        sel_bsr, sel_idcode, sel_bypass, dr_lsb;

    // TAP state register
    always_ff @(posedge tck or negedge trst_l) begin
        if (!trst_l) state <= TLR;
        else         state <= next_state;
    end

    // Standard tms-driven TAP transitions
    always_comb begin
        next_state = TLR;
        case (state)
            TLR:      next_state = tms ? TLR    : RTI;
            RTI:      next_state = tms ? SEL_DR : RTI;
            SEL_DR:   next_state = tms ? SEL_IR : CAP_DR;
            CAP_DR:   next_state = tms ? EX1_DR : SH_DR;
            SH_DR:    next_state = tms ? EX1_DR : SH_DR;
            EX1_DR:   next_state = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: next_state = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   next_state = tms ? UPD_DR : SH_DR;
            UPD_DR:   next_state = tms ? SEL_DR : RTI;
            SEL_IR:   next_state = tms ? TLR    : CAP_IR;
            CAP_IR:   next_state = tms ? EX1_IR : SH_IR;
            SH_IR:    next_state = tms ? EX1_IR : SH_IR;
            EX1_IR:   next_state = tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: next_state = tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   next_state = tms ? UPD_IR : SH_IR;
            UPD_IR:   next_state = tms ? SEL_DR : RTI;
            default:  next_state = TLR;
        endcase
    end

    // IR shift/latch; the latch is forced to IDCODE on the same edge that enters TLR,
    // so the pad-control decode is already clear for the whole time spent in TLR
    always_ff @(posedge tck or negedge trst_l) begin
        if (!trst_l) begin
            ir_shift <= 4'b0001;
            ir_latch <= INS_IDCODE;
        end else begin
            if (state == CAP_IR)     ir_shift <= 4'b0001;
            else if (state == SH_IR) ir_shift <= {tdi, ir_shift[3:1]};
            if (next_state == TLR)   ir_latch <= INS_IDCODE;
            else if (state == UPD_IR) ir_latch <= ir_shift;
        end
    end

    // Instruction decode into DR selection
    always_comb begin
        sel_bsr    = (ir_latch == INS_EXTEST) || (ir_latch == INS_SAMPLE) ||
                     (ir_latch == INS_PS_EXTEST);
        sel_idcode = (ir_latch == INS_IDCODE);
        sel_bypass = !sel_bsr && !sel_idcode;
        dr_lsb     = sel_bsr ? bsr_tail : (sel_idcode ? idcode_reg[0] : bypass_reg);
    end

    // Internal data registers: capture and shift only when selected
    always_ff @(posedge tck or negedge trst_l) begin
        if (!trst_l) begin
            idcode_reg <= IDCODE_VAL;
            bypass_reg <= 1'b0;
        end else if (state == CAP_DR) begin
            if (sel_idcode) idcode_reg <= IDCODE_VAL;
            if (sel_bypass) bypass_reg <= 1'b0;
        end else if (state == SH_DR) begin
            if (sel_idcode) idcode_reg <= {tdi, idcode_reg[31:1]};
            if (sel_bypass) bypass_reg <= tdi;
        end
    end

    // Registered serial out: one cycle behind the shift, zero when not valid
    always_ff @(posedge tck or negedge trst_l) begin
        if (!trst_l) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else if (state == SH_IR) begin
            tdo    <= ir_shift[0];
            tdo_en <= 1'b1;
        end else if (state == SH_DR) begin
            tdo    <= dr_lsb;
            tdo_en <= 1'b1;
        end else begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end
    end

    // Boundary-scan strobes and pad controls; pad controls follow the IR latch only
    always_comb begin
        bsr_si        = tdi;
        shift_dr      = sel_bsr && (state == SH_DR);
        clock_dr      = sel_bsr && ((state == CAP_DR) || (state == SH_DR));
        update_dr     = sel_bsr && (state == UPD_DR);
        mode_ctl      = (ir_latch == INS_EXTEST) || (ir_latch == INS_PS_EXTEST);
        bypass_enable = mode_ctl;
        ps_select     = (ir_latch == INS_PS_EXTEST);
    end

endmodule
